// File: rtl/onehot_encoder.sv
// onehot_encoder: debounced 8-line one-hot to 3-bit binary encoder with illegal-pattern reporting.
// Optional macro ENCODER_PRIORITY_EN: stable multi-hot patterns lock to their highest set line.
module onehot_encoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic In1,
  input  logic In2,
  input  logic In3,
  input  logic In4,
  input  logic In5,
  input  logic In6,
  input  logic In7,
  input  logic In8,
  output logic b2,
  output logic b1,
  output logic b0_LSB,
  output logic valid,
  output logic err,
  output logic changed
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 32'd1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } state_e;

  function automatic logic [3:0] count_ones(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  function automatic logic [2:0] highest_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

  state_e     state_q, state_d;
  logic [7:0] in_q, in_d;
  logic [7:0] cand_q, cand_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic       changed_q, changed_d;
  logic [3:0] cand_ones;
  logic       cand_ok;

  // Decide whether the stable candidate may be published as a legal code.
  always_comb begin
    cand_ones = count_ones(cand_q);
`ifdef ENCODER_PRIORITY_EN
    cand_ok = (cand_ones != 4'd0);
`else
    cand_ok = (cand_ones == 4'd1);
`endif
  end

  // Next-state and next-output logic for the debounce/lock state machine.
  always_comb begin
    in_d      = {In8, In7, In6, In5, In4, In3, In2, In1};
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    valid_d   = valid_q;
    err_d     = err_q;
    changed_d = 1'b0;

    case (state_q)
      IDLE: begin
        cand_d  = in_q;
        cnt_d   = 8'd0;
        state_d = TRACK;
      end

      TRACK: begin
        if (in_q != cand_q) begin
          cand_d = in_q;
          cnt_d  = 8'd0;
        end else if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + 8'd1;
        end else if (cand_ok) begin
          state_d   = LOCKED;
          code_d    = highest_index(cand_q);
          valid_d   = 1'b1;
          err_d     = 1'b0;
          changed_d = 1'b1;
        end else begin
          // Illegal pattern: the last published code stays visible.
          state_d = FAULT;
          valid_d = 1'b0;
          err_d   = 1'b1;
        end
      end

      LOCKED, FAULT: begin
        if (in_q != cand_q) begin
          cand_d  = in_q;
          cnt_d   = 8'd0;
          state_d = TRACK;
        end else begin
          state_d = state_q;
        end
      end

      default: begin
        state_d = IDLE;
        cand_d  = 8'd0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State, input sampling and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      in_q      <= 8'd0;
      cand_q    <= 8'd0;
      cnt_q     <= 8'd0;
      code_q    <= 3'd0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_q      <= in_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      changed_q <= changed_d;
    end
  end

  assign b2      = code_q[2];
  assign b1      = code_q[1];
  assign b0_LSB  = code_q[0];
  assign valid   = valid_q;
  assign err     = err_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_onehot_encoder.sv
// Self-checking bench for onehot_encoder: vector table, hand sequences and randomized runs
// against a run-length reference model, for STABLE_CYCLES=4 and STABLE_CYCLES=1 instances.
module tb_onehot_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] pins = 8'h00;

  logic a_b2, a_b1, a_b0, a_valid, a_err, a_chg;
  logic c_b2, c_b1, c_b0, c_valid, c_err, c_chg;

  int checks = 0;
  int errors = 0;
  int chg_cnt = 0;

  always #5 clk = ~clk;

  onehot_encoder #(.STABLE_CYCLES(4)) dut4 (
    .clk(clk), .reset(rst),
    .In1(pins[0]), .In2(pins[1]), .In3(pins[2]), .In4(pins[3]),
    .In5(pins[4]), .In6(pins[5]), .In7(pins[6]), .In8(pins[7]),
    .b2(a_b2), .b1(a_b1), .b0_LSB(a_b0), .valid(a_valid), .err(a_err), .changed(a_chg)
  );

  onehot_encoder #(.STABLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(rst),
    .In1(pins[0]), .In2(pins[1]), .In3(pins[2]), .In4(pins[3]),
    .In5(pins[4]), .In6(pins[5]), .In7(pins[6]), .In8(pins[7]),
    .b2(c_b2), .b1(c_b1), .b0_LSB(c_b0), .valid(c_valid), .err(c_err), .changed(c_chg)
  );

  // Reference model: a pattern is accepted once it has been sampled STABLE+1 times in a row
  // (counting the zero word captured at reset); acceptance happens once per run.
  typedef struct {
    logic [7:0] prev;
    int         run_len;
    logic [2:0] code;
    logic       valid;
    logic       err;
    logic       changed;
  } mdl_t;

  mdl_t m4, m1;

  function automatic logic qualifies(input logic [7:0] v);
`ifdef ENCODER_PRIORITY_EN
    return $countones(v) != 0;
`else
    return $countones(v) == 1;
`endif
  endfunction

  function automatic logic [2:0] top_line(input logic [7:0] v);
    int idx = 0;
    for (int i = 0; i < 8; i++) if (v[i]) idx = i;
    return 3'(idx);
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input logic r, input logic [7:0] p, input int n);
    mdl_t o = m;
    if (r) begin
      o.prev = 8'h00; o.run_len = 1; o.code = 3'b000;
      o.valid = 1'b0; o.err = 1'b0; o.changed = 1'b0;
      return o;
    end
    o.changed = 1'b0;
    if (m.run_len == n + 1) begin
      if (qualifies(m.prev)) begin
        o.code = top_line(m.prev); o.valid = 1'b1; o.err = 1'b0; o.changed = 1'b1;
      end else begin
        o.valid = 1'b0; o.err = 1'b1;
      end
    end
    if (p == m.prev) o.run_len = (m.run_len < 1000) ? m.run_len + 1 : m.run_len;
    else begin
      o.prev = p; o.run_len = 1;
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare both instances after it.
  task automatic step(input logic r, input logic [7:0] p);
    rst  = r;
    pins = p;
    @(posedge clk);
    m4 = mdl_step(m4, r, p, 4);
    m1 = mdl_step(m1, r, p, 1);
    #1;
    check("cyc_n4", 32'({a_b2, a_b1, a_b0, a_valid, a_err, a_chg}),
          32'({m4.code, m4.valid, m4.err, m4.changed}));
    check("cyc_n1", 32'({c_b2, c_b1, c_b0, c_valid, c_err, c_chg}),
          32'({m1.code, m1.valid, m1.err, m1.changed}));
    if (a_chg === 1'b1) chg_cnt++;
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] pins;
    int         cycles;
    logic [2:0] code;
    logic       valid;
    logic       err;
    int         pulses;
  } vec_t;

  localparam int NV = 11;
  vec_t tbl[NV];

  logic [7:0] last_pat;
  logic [7:0] pat;
  int         hold;

  initial begin
    tbl[0]  = '{1'b1, 8'h00, 2, 3'b000, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b0, 8'h04, 6, 3'b010, 1'b1, 1'b0, 1};
    tbl[2]  = '{1'b0, 8'h04, 3, 3'b010, 1'b1, 1'b0, 0};
    tbl[3]  = '{1'b0, 8'h10, 2, 3'b010, 1'b1, 1'b0, 0};
    tbl[4]  = '{1'b0, 8'h04, 8, 3'b010, 1'b1, 1'b0, 1};
    tbl[5]  = '{1'b0, 8'h00, 6, 3'b010, 1'b0, 1'b1, 0};
`ifdef ENCODER_PRIORITY_EN
    tbl[6]  = '{1'b0, 8'h42, 6, 3'b110, 1'b1, 1'b0, 1};
`else
    tbl[6]  = '{1'b0, 8'h42, 6, 3'b010, 1'b0, 1'b1, 0};
`endif
    tbl[7]  = '{1'b0, 8'h80, 6, 3'b111, 1'b1, 1'b0, 1};
    tbl[8]  = '{1'b1, 8'h80, 1, 3'b000, 1'b0, 1'b0, 0};
    tbl[9]  = '{1'b0, 8'h80, 6, 3'b111, 1'b1, 1'b0, 1};
    tbl[10] = '{1'b0, 8'h01, 3, 3'b111, 1'b1, 1'b0, 0};

    for (int k = 0; k < NV; k++) begin
      chg_cnt = 0;
      for (int c = 0; c < tbl[k].cycles; c++) step(tbl[k].rst, tbl[k].pins);
      check($sformatf("vec%0d_out", k), 32'({a_b2, a_b1, a_b0, a_valid, a_err}),
            32'({tbl[k].code, tbl[k].valid, tbl[k].err}));
      check($sformatf("vec%0d_pulses", k), 32'(chg_cnt), 32'(tbl[k].pulses));
    end

    // Exact latency at STABLE_CYCLES=4: nothing for 5 edges, lock on the 6th, pulse lasts one cycle.
    step(1'b1, 8'h00);
    for (int e = 1; e <= 5; e++) begin
      step(1'b0, 8'h04);
      check($sformatf("lat4_e%0d", e), 32'({a_valid, a_chg}), 32'(2'b00));
    end
    step(1'b0, 8'h04);
    check("lat4_e6", 32'({a_b2, a_b1, a_b0, a_valid, a_err, a_chg}), 32'(6'b010101));
    step(1'b0, 8'h04);
    check("lat4_e7_pulse_end", 32'({a_valid, a_chg}), 32'(2'b10));

    // STABLE_CYCLES=1: In1 held after reset locks to 000 after 3 edges.
    step(1'b1, 8'h00);
    step(1'b0, 8'h01);
    check("n1_e1", 32'(c_valid), 32'(1'b0));
    step(1'b0, 8'h01);
    check("n1_e2", 32'(c_valid), 32'(1'b0));
    step(1'b0, 8'h01);
    check("n1_e3", 32'({c_b2, c_b1, c_b0, c_valid, c_err, c_chg}), 32'(6'b000101));

    // Randomized runs with glitches back to the previous pattern and occasional resets.
    last_pat = 8'h01;
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: pat = 8'(1 << $urandom_range(0, 7));
        5, 6:          pat = last_pat;
        7:             pat = 8'h00;
        default:       pat = 8'($urandom_range(0, 255));
      endcase
      hold = $urandom_range(1, 8);
      for (int c = 0; c < hold; c++) step(($urandom_range(0, 99) == 0), pat);
      last_pat = pat;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
